periph_timer: RTL and testbench
===============================

# periph_timer

Memory-mapped 64-bit timer/compare peripheral that responds to the core's `d_*` peripheral data bus. It decodes its own address window and acknowledges each access with a one-cycle `d_ready` pulse after a fixed number of wait states. It raises an interrupt line intended for one bit of the core's `interrupt_sources`.

## Interface
- `BASE_ADDR`, 64'h2000_1000: window base; must be 64-byte aligned and at or above the core's `PERIPHERAL_BASE`.
- `WAIT_STATES`, 1: idle cycles between accept and `d_ready`; legal range 0..15.
- `clock`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `d_addr`  in  64  access byte address.
- `d_wdata`  in  64  store data, right-aligned (low bits).
- `d_store_type`  in  `mem_store_type_t`  `MEM_STORE_NONE` = read; `MEM_STORE_BYTE`, `MEM_STORE_HALF`, `MEM_STORE_WORD` and `MEM_STORE_DOUBLE` = store.
- `d_valid`  in  1  request; held high by the core until `d_ready`.
- `d_rdata`  out  64  read data; valid only while `d_ready`=1, otherwise 0.
- `d_ready`  out  1  one-cycle acknowledge.
- `irq`  out  1  level interrupt.

## Operation
- Hit: `d_valid` && `d_addr[63:6]` == `BASE_ADDR[63:6]`. Non-hits are ignored entirely, because `d_valid` is also driven for L2 traffic.
- FSM states:
  - IDLE: on a hit, latch addr/wdata/type and go to WAIT, or to RESP if `WAIT_STATES`=0.
  - WAIT: count down `WAIT_STATES`, then go to RESP.
  - RESP: `d_ready`=1 for exactly one cycle, then return to IDLE.
- Registers, by offset `d_addr[5:3]`:
  - 0x00 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
  - 0x08 COUNT.
  - 0x10 COMPARE.
  - 0x18 STATUS: bit0 MATCH, write-1-to-clear.
  - 0x20 PRESCALE: see Configuration.
  - 0x28–0x38: read 0, writes ignored, still acknowledged.
- Reads: `d_rdata` = reg >> (8·`d_addr[2:0]`). The core performs extension.
- Stores merge bytes into lanes starting at `d_addr[2:0]`.
  - A misaligned store (half with addr[0]≠0, word with addr[1:0]≠0, double with addr[2:0]≠0) writes nothing but is acknowledged.
- Tick: asserted each cycle while EN=1 (subject to the prescaler).
  - On a tick, if COUNT == COMPARE: set MATCH; COUNT ← 0 if AUTO_RELOAD, else COUNT+1.
  - Otherwise on a tick: COUNT ← COUNT+1, wrapping mod 2^64.
- `irq` = MATCH & IRQ_EN, registered.
- Simultaneous events:
  - A bus write to COUNT beats a tick increment.
  - A MATCH set beats a W1C clear in the same cycle.
  - A COMPARE write takes effect for the next tick.

## Timing
- Reset values: `d_ready`=0, `d_rdata`=0, `irq`=0, FSM=IDLE, all registers 0.
- Accept at cycle t → `d_ready` at t+1+`WAIT_STATES` (t+1 when 0).
- `d_rdata` reflects register state in the RESP cycle.
- Stores commit on the clock edge that ends RESP.
- Back-to-back: a new hit is accepted in the IDLE cycle right after RESP, so the minimum spacing between acknowledges is 2+`WAIT_STATES` cycles.
- `irq` rises 1 cycle after MATCH is set and falls 1 cycle after MATCH clears or IRQ_EN is written 0.
- Reset asserted mid-access: FSM returns to IDLE and `d_ready`/`d_rdata` drop immediately (asynchronous). The pending store is discarded.

## Configuration
- `PERIPH_TIMER_PRESCALER_EN` defined:
  - PRESCALE[15:0] is read/write.
  - A tick occurs once every PRESCALE+1 enabled cycles, using an internal 16-bit divider.
  - The divider clears when EN=0 or when PRESCALE is written.
- Undefined: a tick occurs every enabled cycle, PRESCALE reads 0, and writes to it are ignored.

## Structure
- The shared `structures` package holds:
  - register offset constants `TIMER_CTRL_OFF` … `TIMER_PRESCALE_OFF`;
  - CTRL bit-index constants;
  - a `timer_state_t` enum {IDLE, WAIT, RESP}.
- `mem_store_type_t` is reused from the package as-is.
- One sub-module, `periph_bus_resp`: the generic hit/FSM/wait-state/byte-merge front end, reusable by later peripherals. It presents a latched offset, write strobe, byte-enable mask and a read-data mux input.

## Test plan
- Reset, then read CTRL at `BASE_ADDR` with `WAIT_STATES`=1 → `d_ready` at t+2, `d_rdata`=0; no `d_ready` at t+1 or t+3.
- Write COMPARE=5, CTRL=0b011 → MATCH set on the tick where COUNT=5; `irq`=1 the following cycle; a STATUS write of 1 clears `irq` one cycle later.
- AUTO_RELOAD with COMPARE=2 → COUNT sequence 0,1,2,0,1,2; MATCH set every third tick.
- Byte store 0xAB to `BASE_ADDR`+0x09 → COUNT[15:8]=0xAB with other bytes unchanged; half store to +0x09 → no change, still acknowledged.
- `d_valid` with `d_addr`=`BASE_ADDR`+0x40 → no `d_ready` ever; assert reset during WAIT → `d_ready` stays 0 and COMPARE is unchanged.
- With the macro defined, PRESCALE=3, EN=1 → COUNT increments once every 4 cycles; without the macro, PRESCALE reads 0.

Source files
------------

// File: rtl/structures.sv
// Shared definitions for the peripheral data bus and the timer register map.
// Register offsets are 8-byte word indices, i.e. d_addr[5:3].
package structures;

  typedef enum logic [2:0] {
    MEM_STORE_NONE   = 3'd0,
    MEM_STORE_BYTE   = 3'd1,
    MEM_STORE_HALF   = 3'd2,
    MEM_STORE_WORD   = 3'd3,
    MEM_STORE_DOUBLE = 3'd4
  } mem_store_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } timer_state_t;

  localparam logic [2:0] TIMER_CTRL_OFF     = 3'd0;
  localparam logic [2:0] TIMER_COUNT_OFF    = 3'd1;
  localparam logic [2:0] TIMER_COMPARE_OFF  = 3'd2;
  localparam logic [2:0] TIMER_STATUS_OFF   = 3'd3;
  localparam logic [2:0] TIMER_PRESCALE_OFF = 3'd4;

  localparam int CTRL_EN_BIT          = 0;
  localparam int CTRL_IRQ_EN_BIT      = 1;
  localparam int CTRL_AUTO_RELOAD_BIT = 2;

  // Byte-enable pattern of a store before it is shifted to its starting lane.
  function automatic logic [7:0] store_byte_mask(input mem_store_type_t st);
    case (st)
      MEM_STORE_BYTE:   return 8'h01;
      MEM_STORE_HALF:   return 8'h03;
      MEM_STORE_WORD:   return 8'h0F;
      MEM_STORE_DOUBLE: return 8'hFF;
      default:          return 8'h00;
    endcase
  endfunction

  function automatic logic store_aligned(input mem_store_type_t st, input logic [2:0] lane);
    case (st)
      MEM_STORE_HALF:   return lane[0] == 1'b0;
      MEM_STORE_WORD:   return lane[1:0] == 2'b00;
      MEM_STORE_DOUBLE: return lane == 3'b000;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
    logic [63:0] merged;
    merged = old_val;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/periph_bus_resp.sv
// Generic d_* bus front end: window decode, IDLE/WAIT/RESP handshake with fixed
// wait states, and byte-lane alignment of store data and read data.
module periph_bus_resp
  import structures::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h2000_1000,
  parameter int          WAIT_STATES = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     d_addr,
  input  logic [63:0]     d_wdata,
  input  mem_store_type_t d_store_type,
  input  logic            d_valid,
  output logic [63:0]     d_rdata,
  output logic            d_ready,
  output logic [2:0]      reg_off,
  output logic            wr_en,
  output logic [7:0]      wr_be,
  output logic [63:0]     wr_data,
  input  logic [63:0]     rd_data
);

  timer_state_t    state, state_next;
  logic [3:0]      wait_cnt, wait_cnt_next;
  logic [5:0]      addr_q;
  logic [63:0]     wdata_q;
  mem_store_type_t type_q;
  logic            hit;
  logic [2:0]      lane;

  // Only the upper address bits select the window; L2 traffic shares d_valid.
  assign hit = d_valid && (d_addr[63:6] == BASE_ADDR[63:6]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 6'd0;
      wdata_q  <= 64'd0;
      type_q   <= MEM_STORE_NONE;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == IDLE && hit) begin
        addr_q  <= d_addr[5:0];
        wdata_q <= d_wdata;
        type_q  <= d_store_type;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE: begin
        if (hit) begin
          if (WAIT_STATES == 0) begin
            state_next = RESP;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = 4'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_next = RESP;
        else                  wait_cnt_next = wait_cnt - 4'd1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign lane    = addr_q[2:0];
  assign reg_off = addr_q[5:3];
  assign d_ready = (state == RESP);
  assign d_rdata = d_ready ? (rd_data >> {lane, 3'b000}) : 64'd0;

  // Misaligned stores still get d_ready but never raise the write strobe.
  assign wr_be   = store_byte_mask(type_q) << lane;
  assign wr_data = wdata_q << {lane, 3'b000};
  assign wr_en   = d_ready && (type_q != MEM_STORE_NONE) && store_aligned(type_q, lane);

endmodule

// File: rtl/periph_timer.sv
// 64-bit timer/compare peripheral on the d_* bus with a level interrupt.
// Optional prescaler is built when PERIPH_TIMER_PRESCALER_EN is defined.
module periph_timer
  import structures::*;
#(
  parameter logic [63:0] BASE_ADDR   = 64'h2000_1000,
  parameter int          WAIT_STATES = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [63:0]     d_addr,
  input  logic [63:0]     d_wdata,
  input  mem_store_type_t d_store_type,
  input  logic            d_valid,
  output logic [63:0]     d_rdata,
  output logic            d_ready,
  output logic            irq
);

  logic [2:0]  reg_off;
  logic        wr_en;
  logic [7:0]  wr_be;
  logic [63:0] wr_data;
  logic [63:0] rd_data;

  logic [2:0]  ctrl;
  logic [63:0] count;
  logic [63:0] compare;
  logic        match;
  logic        tick;
  logic        match_hit;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;

  periph_bus_resp #(
    .BASE_ADDR   (BASE_ADDR),
    .WAIT_STATES (WAIT_STATES)
  ) u_bus (
    .clock        (clock),
    .reset        (reset),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_store_type (d_store_type),
    .d_valid      (d_valid),
    .d_rdata      (d_rdata),
    .d_ready      (d_ready),
    .reg_off      (reg_off),
    .wr_en        (wr_en),
    .wr_be        (wr_be),
    .wr_data      (wr_data),
    .rd_data      (rd_data)
  );

  assign wr_ctrl    = wr_en && (reg_off == TIMER_CTRL_OFF);
  assign wr_count   = wr_en && (reg_off == TIMER_COUNT_OFF);
  assign wr_compare = wr_en && (reg_off == TIMER_COMPARE_OFF);
  assign wr_status  = wr_en && (reg_off == TIMER_STATUS_OFF);

`ifdef PERIPH_TIMER_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] div;
  logic        wr_prescale;

  assign wr_prescale = wr_en && (reg_off == TIMER_PRESCALE_OFF);
  assign tick        = ctrl[CTRL_EN_BIT] && (div == prescale);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescale <= 16'd0;
      div      <= 16'd0;
    end else begin
      if (wr_prescale && wr_be[0]) prescale[7:0]  <= wr_data[7:0];
      if (wr_prescale && wr_be[1]) prescale[15:8] <= wr_data[15:8];
      if (!ctrl[CTRL_EN_BIT] || wr_prescale || tick) div <= 16'd0;
      else                                           div <= div + 16'd1;
    end
  end
`else
  assign tick = ctrl[CTRL_EN_BIT];
`endif

  assign match_hit = tick && (count == compare);

  always_comb begin
    rd_data = 64'd0;
    case (reg_off)
      TIMER_CTRL_OFF:     rd_data = {61'd0, ctrl};
      TIMER_COUNT_OFF:    rd_data = count;
      TIMER_COMPARE_OFF:  rd_data = compare;
      TIMER_STATUS_OFF:   rd_data = {63'd0, match};
`ifdef PERIPH_TIMER_PRESCALER_EN
      TIMER_PRESCALE_OFF: rd_data = {48'd0, prescale};
`endif
      default:            rd_data = 64'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl    <= 3'd0;
      count   <= 64'd0;
      compare <= 64'd0;
      match   <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl && wr_be[0]) ctrl <= wr_data[2:0];

      // A bus write replaces the tick update entirely.
      if (wr_count)
        count <= byte_merge(count, wr_data, wr_be);
      else if (tick)
        count <= (match_hit && ctrl[CTRL_AUTO_RELOAD_BIT]) ? 64'd0 : count + 64'd1;

      if (wr_compare) compare <= byte_merge(compare, wr_data, wr_be);

      if (match_hit)                             match <= 1'b1;
      else if (wr_status && wr_be[0] && wr_data[0]) match <= 1'b0;

      irq <= match & ctrl[CTRL_IRQ_EN_BIT];
    end
  end

endmodule

// File: tb/tb_periph_timer.sv
// Directed bench for periph_timer: a cycle-level register model checked against
// the DUT outputs every cycle, plus hand-computed literal expectations.
module tb_periph_timer;
  import structures::*;

  localparam logic [63:0] BASE = 64'h2000_1000;
  localparam int          WS   = 1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [63:0]     d_addr = 64'd0;
  logic [63:0]     d_wdata = 64'd0;
  mem_store_type_t d_store_type = MEM_STORE_NONE;
  logic            d_valid = 1'b0;
  logic [63:0]     d_rdata;
  logic            d_ready;
  logic            irq;

  int tests = 0;
  int fails = 0;

  periph_timer #(.BASE_ADDR(BASE), .WAIT_STATES(WS)) dut (
    .clock        (clock),
    .reset        (reset),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_store_type (d_store_type),
    .d_valid      (d_valid),
    .d_rdata      (d_rdata),
    .d_ready      (d_ready),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          busy = 0;
  int          resp_at = 0;
  logic [63:0] a_addr = 64'd0;
  logic [63:0] a_wdata = 64'd0;
  mem_store_type_t a_type = MEM_STORE_NONE;
  logic [2:0]  m_ctrl = 3'd0;
  logic [63:0] m_count = 64'd0;
  logic [63:0] m_compare = 64'd0;
  logic        m_match = 1'b0;
  logic        m_irq = 1'b0;
`ifdef PERIPH_TIMER_PRESCALER_EN
  logic [15:0] m_pres = 16'd0;
  int          m_div = 0;
`endif

  function automatic logic [63:0] model_reg(input logic [2:0] off);
    case (off)
      3'd0: return {61'd0, m_ctrl};
      3'd1: return m_count;
      3'd2: return m_compare;
      3'd3: return {63'd0, m_match};
`ifdef PERIPH_TIMER_PRESCALER_EN
      3'd4: return {48'd0, m_pres};
`endif
      default: return 64'd0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc = 0; busy = 0; resp_at = 0;
      m_ctrl = 3'd0; m_count = 64'd0; m_compare = 64'd0; m_match = 1'b0; m_irq = 1'b0;
`ifdef PERIPH_TIMER_PRESCALER_EN
      m_pres = 16'd0; m_div = 0;
`endif
    end else begin
      logic        tk, set_m, clr_m;
      logic [2:0]  n_ctrl;
      logic [63:0] n_count, n_compare;
      logic        n_match, n_irq;
      int          sz, l0;
`ifdef PERIPH_TIMER_PRESCALER_EN
      logic [15:0] n_pres;
      int          n_div;
      tk     = m_ctrl[0] && (m_div == int'(m_pres));
      n_pres = m_pres;
      n_div  = (!m_ctrl[0] || tk) ? 0 : m_div + 1;
`else
      tk = m_ctrl[0];
`endif
      n_ctrl = m_ctrl; n_compare = m_compare; n_match = m_match;
      n_count = m_count;
      set_m = 1'b0; clr_m = 1'b0;
      if (tk) begin
        if (m_count == m_compare) begin
          set_m   = 1'b1;
          n_count = m_ctrl[2] ? 64'd0 : m_count + 64'd1;
        end else begin
          n_count = m_count + 64'd1;
        end
      end
      n_irq = m_match & m_ctrl[1];

      if (busy && cyc == resp_at) begin
        case (a_type)
          MEM_STORE_BYTE:   sz = 1;
          MEM_STORE_HALF:   sz = 2;
          MEM_STORE_WORD:   sz = 4;
          MEM_STORE_DOUBLE: sz = 8;
          default:          sz = 0;
        endcase
        l0 = int'(a_addr[2:0]);
        if (sz > 0 && (l0 % sz) == 0) begin
          if (a_addr[5:3] == 3'd1) n_count = m_count;
`ifdef PERIPH_TIMER_PRESCALER_EN
          if (a_addr[5:3] == 3'd4) n_div = 0;
`endif
          for (int i = 0; i < sz; i++) begin
            int         ln;
            logic [7:0] b;
            ln = l0 + i;
            b  = a_wdata[8*i +: 8];
            case (a_addr[5:3])
              3'd0: if (ln == 0) n_ctrl = b[2:0];
              3'd1: n_count[8*ln +: 8] = b;
              3'd2: n_compare[8*ln +: 8] = b;
              3'd3: if (ln == 0 && b[0]) clr_m = 1'b1;
`ifdef PERIPH_TIMER_PRESCALER_EN
              3'd4: if (ln < 2) n_pres[8*ln +: 8] = b;
`endif
              default: ;
            endcase
          end
        end
        busy = 0;
      end else if (!busy && d_valid && d_addr[63:6] == BASE[63:6]) begin
        busy = 1; resp_at = cyc + 1 + WS;
        a_addr = d_addr; a_wdata = d_wdata; a_type = d_store_type;
      end

      if (set_m)      n_match = 1'b1;
      else if (clr_m) n_match = 1'b0;

      m_ctrl = n_ctrl; m_count = n_count; m_compare = n_compare;
      m_match = n_match; m_irq = n_irq;
`ifdef PERIPH_TIMER_PRESCALER_EN
      m_pres = n_pres; m_div = n_div;
`endif
      cyc++;
    end
  end

  // One compare process, away from the active edge.
  always @(negedge clock) begin
    logic        exp_ready;
    logic [63:0] exp_rdata;
    exp_ready = busy && (cyc == resp_at);
    exp_rdata = exp_ready ? (model_reg(a_addr[5:3]) >> (8 * int'(a_addr[2:0]))) : 64'd0;
    check("cyc_d_ready", {63'd0, d_ready}, {63'd0, exp_ready});
    check("cyc_d_rdata", d_rdata, exp_rdata);
    check("cyc_irq", {63'd0, irq}, {63'd0, m_irq});
  end

  // ---------------- bus helpers ----------------
  task automatic bus_access(input logic [63:0] addr, input mem_store_type_t st,
                            input logic [63:0] wdata, output logic [63:0] rdata,
                            output int lat);
    bit got;
    @(negedge clock);
    d_addr = addr; d_wdata = wdata; d_store_type = st; d_valid = 1'b1;
    got = 0; lat = 0; rdata = 64'd0;
    for (int i = 1; i <= 50 && !got; i++) begin
      @(negedge clock);
      if (d_ready) begin
        got = 1; lat = i; rdata = d_rdata;
      end
    end
    d_valid = 1'b0; d_store_type = MEM_STORE_NONE;
    if (!got) begin
      tests++; fails++;
      $display("FAIL ack_timeout: no d_ready for addr %0h within 50 cycles", addr);
    end
  endtask

  task automatic wr(input logic [5:0] off, input mem_store_type_t st, input logic [63:0] data,
                    output int lat);
    logic [63:0] unused_rd;
    bus_access(BASE + {58'd0, off}, st, data, unused_rd, lat);
  endtask

  task automatic rd(input logic [5:0] off, output logic [63:0] data, output int lat);
    bus_access(BASE + {58'd0, off}, MEM_STORE_NONE, 64'd0, data, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [63:0] v, v1;
    int          lat, n;

    repeat (3) @(negedge clock);
    #1 reset = 1'b0;

    // Reset read of CTRL: ack exactly two cycles after drive.
    rd(6'h00, v, lat);
    check("ctrl_reset_val", v, 64'd0);
    check("ctrl_read_latency", 64'(lat), 64'd2);

    // Byte-lane merges into COUNT (timer disabled).
    wr(6'h08, MEM_STORE_DOUBLE, 64'h1122_3344_5566_7788, lat);
    wr(6'h09, MEM_STORE_BYTE, 64'h0000_0000_0000_00AB, lat);
    rd(6'h08, v, lat);
    check("count_byte_store", v, 64'h1122_3344_5566_AB88);
    wr(6'h09, MEM_STORE_HALF, 64'h0000_0000_0000_FFFF, lat);
    check("misaligned_half_ack", 64'(lat), 64'd2);
    rd(6'h08, v, lat);
    check("count_after_misaligned", v, 64'h1122_3344_5566_AB88);
    rd(6'h0A, v, lat);
    check("count_shifted_read", v, 64'h0000_1122_3344_5566);
    rd(6'h30, v, lat);
    check("reserved_read", v, 64'd0);

    // Compare match with interrupt.
    wr(6'h08, MEM_STORE_DOUBLE, 64'd0, lat);
    wr(6'h10, MEM_STORE_DOUBLE, 64'd5, lat);
    wr(6'h00, MEM_STORE_DOUBLE, 64'b011, lat);
    n = 0;
    for (int i = 1; i <= 30 && n == 0; i++) begin
      @(negedge clock);
      if (irq) n = i;
    end
    check("irq_rise_latency", 64'(n), 64'd8);
    rd(6'h18, v, lat);
    check("status_match_set", v, 64'd1);
    wr(6'h18, MEM_STORE_DOUBLE, 64'd1, lat);
    @(negedge clock);
    check("irq_hold_after_w1c", {63'd0, irq}, 64'd1);
    @(negedge clock);
    check("irq_fall_after_w1c", {63'd0, irq}, 64'd0);

    // Auto-reload with COMPARE=2.
    wr(6'h00, MEM_STORE_DOUBLE, 64'd0, lat);
    wr(6'h08, MEM_STORE_DOUBLE, 64'd0, lat);
    wr(6'h10, MEM_STORE_DOUBLE, 64'd2, lat);
    wr(6'h18, MEM_STORE_DOUBLE, 64'd1, lat);
    wr(6'h00, MEM_STORE_DOUBLE, 64'b101, lat);
    for (int i = 0; i < 6; i++) begin
      rd(6'h08, v, lat);
      check("autoreload_range", 64'(v < 64'd3), 64'd1);
    end
    rd(6'h18, v, lat);
    check("autoreload_match", v, 64'd1);

    // Prescaler: ticks counted over a 16-cycle window.
    wr(6'h00, MEM_STORE_DOUBLE, 64'd0, lat);
    wr(6'h08, MEM_STORE_DOUBLE, 64'd0, lat);
    wr(6'h10, MEM_STORE_DOUBLE, 64'hFFFF, lat);
    wr(6'h20, MEM_STORE_DOUBLE, 64'd3, lat);
    rd(6'h20, v, lat);
`ifdef PERIPH_TIMER_PRESCALER_EN
    check("prescale_readback", v, 64'd3);
`else
    check("prescale_reads_zero", v, 64'd0);
`endif
    wr(6'h00, MEM_STORE_DOUBLE, 64'd1, lat);
    rd(6'h08, v1, lat);
    repeat (13) @(negedge clock);
    rd(6'h08, v, lat);
`ifdef PERIPH_TIMER_PRESCALER_EN
    check("prescaled_tick_rate", v - v1, 64'd4);
`else
    check("unscaled_tick_rate", v - v1, 64'd16);
`endif
    wr(6'h00, MEM_STORE_DOUBLE, 64'd0, lat);

    // Out-of-window request is never acknowledged.
    @(negedge clock);
    d_addr = BASE + 64'h40; d_store_type = MEM_STORE_NONE; d_valid = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (d_ready) n++;
    end
    d_valid = 1'b0;
    check("out_of_window_no_ready", 64'(n), 64'd0);

    // Reset during RESP drops d_ready/d_rdata at once.
    wr(6'h10, MEM_STORE_DOUBLE, 64'h77, lat);
    @(negedge clock);
    d_addr = BASE + 64'h10; d_store_type = MEM_STORE_NONE; d_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clock);
      if (d_ready) n = 1;
    end
    check("resp_before_reset_rdata", d_rdata, 64'h77);
    #1 reset = 1'b1;
    d_valid = 1'b0;
    #1 check("reset_drops_ready", {63'd0, d_ready}, 64'd0);
    check("reset_drops_rdata", d_rdata, 64'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;

    // Reset during WAIT discards the pending store.
    wr(6'h10, MEM_STORE_DOUBLE, 64'h77, lat);
    @(negedge clock);
    d_addr = BASE + 64'h10; d_wdata = 64'h99; d_store_type = MEM_STORE_DOUBLE; d_valid = 1'b1;
    @(negedge clock);
    #1 reset = 1'b1;
    d_valid = 1'b0; d_store_type = MEM_STORE_NONE;
    #1 check("reset_in_wait_no_ready", {63'd0, d_ready}, 64'd0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    rd(6'h10, v, lat);
    check("compare_after_aborted_store", v, 64'd0);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
